cordic_rr_sched: RTL and testbench

//  Shares one backpressured CORDIC pipeline (pipe_ctrl + stages) between N_REQ AXI-Stream requesters.

---
 rtl/cordic_rr_sched_pkg.sv | 34 +++
 rtl/cordic_rr_sched_tag_fifo.sv | 71 +++++++
 rtl/cordic_rr_sched.sv | 130 +++++++++++++
 tb/tb_cordic_rr_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_rr_sched_pkg.sv
// Shared types and helpers for the CORDIC round-robin scheduler slice.
package cordic_sched_pkg;

  localparam int unsigned CORDIC_STAGES = 6;
  localparam int unsigned MAX_REQ       = 32;
  localparam int unsigned MAX_REQ_W     = 5;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } issue_state_e;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester with valid set, scanning ptr, ptr+1, ... mod n.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned         ptr,
                                          input int unsigned         n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if ((k < n) && !found && valid[idx[MAX_REQ_W-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cordic_rr_sched_tag_fifo.sv
// Synchronous tag FIFO recording the requester index of every issued beat.
module cordic_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = next_ptr(wr_q);
    end
    if (do_pop) begin
      rd_d = next_ptr(rd_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin sharing of one in-order CORDIC pipeline between N_REQ AXI-Stream requesters.
module cordic_rr_sched
  import cordic_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [N_REQ-1:0]                 req_tvalid,
  output logic [N_REQ-1:0]                 req_tready,
  input  logic [N_REQ*DATA_W-1:0]          req_tdata,
  output logic [N_REQ-1:0]                 rsp_tvalid,
  input  logic [N_REQ-1:0]                 rsp_tready,
  output logic [RES_W-1:0]                 rsp_tdata,
  output logic                             pipe_tvalid_o,
  input  logic                             pipe_tready_i,
  output logic [DATA_W-1:0]                pipe_tdata_o,
  input  logic                             pipe_tvalid_i,
  output logic                             pipe_tready_o,
  input  logic [RES_W-1:0]                 pipe_tdata_i,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   inflight,
  output logic                             err
);

  localparam int unsigned TAG_W = tag_w(N_REQ);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

  if (TAG_DEPTH < CORDIC_STAGES) begin : g_depth_chk
    $error("cordic_rr_sched: TAG_DEPTH must cover the pipeline stage count");
  end
  if ((N_REQ < 2) || (N_REQ > MAX_REQ)) begin : g_nreq_chk
    $error("cordic_rr_sched: N_REQ out of supported range");
  end

  issue_state_e     state_q, state_d;
  logic [TAG_W-1:0] grant_q, grant_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] grant;
  logic             offer, push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [TAG_W-1:0] head_tag;
  logic [CNT_W-1:0] fifo_count;

  cordic_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk    (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    (grant),
    .dout   (head_tag),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Issue side: once an offer stalls, the grant is frozen so pipe_tdata_o
  // stays stable until the pipeline accepts it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (state_q == ST_LOCKED) begin
      grant = grant_q;
      offer = 1'b1;
    end else begin
      grant = TAG_W'(rr_pick(MAX_REQ'(req_tvalid), 32'(ptr_q), N_REQ));
      offer = (|req_tvalid) && !fifo_full;
    end
    if (areset) begin
      offer = 1'b0;
    end
    push = offer && pipe_tready_i;
    if (push) begin
      state_d = ST_IDLE;
      ptr_d   = (grant == TAG_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (offer) begin
      state_d = ST_LOCKED;
      grant_d = grant;
    end
  end

  assign pipe_tvalid_o = offer;
  assign pipe_tdata_o  = req_tdata[grant*DATA_W +: DATA_W];
  assign req_tready    = push ? (N_REQ'(1) << grant) : '0;

  // Return side: results steered to the FIFO head; beats with no tag are dropped.
  always_comb begin
    rsp_tvalid    = '0;
    pipe_tready_o = 1'b0;
    pop           = 1'b0;
    drop          = 1'b0;
    if (!areset) begin
      if (fifo_empty) begin
        pipe_tready_o = 1'b1;
        drop          = pipe_tvalid_i;
      end else begin
        rsp_tvalid[head_tag] = pipe_tvalid_i;
        pipe_tready_o        = rsp_tready[head_tag];
        pop                  = pipe_tvalid_i && rsp_tready[head_tag];
      end
    end
    err_d = err_q || drop;
  end

  assign rsp_tdata = pipe_tdata_i;
  assign inflight  = fifo_count;
  assign err       = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed plus randomized bench with a loopback 6-cycle pipeline and a queue-based reference.
module tb_cordic_rr_sched;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 6;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_tvalid, req_tready, rsp_tvalid, rsp_tready;
  logic [N*DW-1:0] req_tdata;
  logic [RW-1:0]   rsp_tdata;
  logic            pipe_tvalid_o, pipe_tready_i, pipe_tvalid_i, pipe_tready_o;
  logic [DW-1:0]   pipe_tdata_o;
  logic [RW-1:0]   pipe_tdata_i;
  logic [3:0]      inflight;
  logic            err;

  cordic_rr_sched #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .RES_W     (RW),
    .TAG_DEPTH (DEPTH)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_tvalid    (req_tvalid),
    .req_tready    (req_tready),
    .req_tdata     (req_tdata),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tready    (rsp_tready),
    .rsp_tdata     (rsp_tdata),
    .pipe_tvalid_o (pipe_tvalid_o),
    .pipe_tready_i (pipe_tready_i),
    .pipe_tdata_o  (pipe_tdata_o),
    .pipe_tvalid_i (pipe_tvalid_i),
    .pipe_tready_o (pipe_tready_o),
    .pipe_tdata_i  (pipe_tdata_i),
    .inflight      (inflight),
    .err           (err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    int unsigned   due;
    logic [RW-1:0] res;
  } pent_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  logic [DW-1:0] src_q   [N][$];
  logic [RW-1:0] exp_res [N][$];
  pent_t         pq[$];
  int            tagq[$];
  int            ilog[$];
  int            rlog[$];
  int unsigned   icyc[$];

  int unsigned ptr_m;
  int unsigned lockg_m;
  bit          locked_m;
  bit          err_m;

  logic [N-1:0] rsp_en;
  bit           pipe_rdy;
  bit           inj;

  logic         s_pvo, s_issue, s_ptro;
  logic [3:0]   s_inflight;
  logic [N-1:0] s_rspv;
  logic         s_err;
  logic [DW-1:0] s_pdo;
  int unsigned  peak;

  function automatic logic [RW-1:0] xform(input logic [DW-1:0] d);
    return {d[15:0], d[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (tagq.size() > 0) || (pq.size() > 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = (src_q[i].size() > 0);
      if (src_q[i].size() > 0) req_tdata[i*DW +: DW] = src_q[i][0];
      else                      req_tdata[i*DW +: DW] = '0;
    end
    rsp_tready    = rsp_en;
    pipe_tready_i = pipe_rdy;
    if (inj) begin
      pipe_tvalid_i = 1'b1;
      pipe_tdata_i  = 32'hDEAD_BEEF;
    end else if ((pq.size() > 0) && (pq[0].due <= cyc)) begin
      pipe_tvalid_i = 1'b1;
      pipe_tdata_i  = pq[0].res;
    end else begin
      pipe_tvalid_i = 1'b0;
      pipe_tdata_i  = '0;
    end
  endtask

  task automatic sample();
    int unsigned  g, idx, h;
    bit           any, exp_pvo, issue_m;
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] d;
    logic [RW-1:0] e, r;
    s_pvo      = pipe_tvalid_o;
    s_ptro     = pipe_tready_o;
    s_inflight = inflight;
    s_rspv     = rsp_tvalid;
    s_err      = err;
    s_pdo      = pipe_tdata_o;
    s_issue    = 1'b0;
    if (areset) begin
      check("rst_req_tready", req_tready, '0);
      check("rst_rsp_tvalid", rsp_tvalid, '0);
      check("rst_pipe_tvalid_o", pipe_tvalid_o, 0);
      check("rst_pipe_tready_o", pipe_tready_o, 0);
      tagq.delete();
      pq.delete();
      for (int i = 0; i < N; i++) exp_res[i].delete();
      locked_m = 1'b0;
      ptr_m    = 0;
      err_m    = 1'b0;
      return;
    end
    any = 1'b0;
    g   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (ptr_m + k) % N;
      if (src_q[idx].size() > 0) begin
        g   = idx;
        any = 1'b1;
      end
    end
    if (locked_m) g = lockg_m;
    exp_pvo = locked_m || (any && (tagq.size() < DEPTH));
    check("pipe_tvalid_o", pipe_tvalid_o, exp_pvo);
    if (exp_pvo) check("pipe_tdata_o", pipe_tdata_o, src_q[g][0]);
    exp_rdy = (exp_pvo && pipe_tready_i) ? (N'(1) << g) : '0;
    check("req_tready", req_tready, exp_rdy);
    check("inflight", inflight, tagq.size());
    check("err", err, err_m);
    if (peak < inflight) peak = inflight;

    if (pipe_tvalid_i && (tagq.size() == 0)) begin
      check("drop_rsp_tvalid", rsp_tvalid, '0);
      check("drop_pipe_tready_o", pipe_tready_o, 1);
      err_m = 1'b1;
      if (!inj && (pq.size() > 0)) void'(pq.pop_front());
    end else if (pipe_tvalid_i) begin
      h = tagq[0];
      check("rsp_tvalid", rsp_tvalid, N'(1) << h);
      check("pipe_tready_o", pipe_tready_o, rsp_tready[h]);
      check("rsp_tdata", rsp_tdata, pipe_tdata_i);
      if (rsp_tready[h]) begin
        e = exp_res[h].pop_front();
        check("rsp_result", rsp_tdata, e);
        void'(tagq.pop_front());
        void'(pq.pop_front());
        rlog.push_back(h);
      end
    end else begin
      check("rsp_tvalid_idle", rsp_tvalid, '0);
    end

    issue_m = exp_pvo && pipe_tready_i;
    if (issue_m) begin
      d = src_q[g].pop_front();
      r = xform(d);
      pq.push_back('{due: cyc + LAT, res: r});
      exp_res[g].push_back(r);
      tagq.push_back(g);
      ilog.push_back(g);
      icyc.push_back(cyc);
      locked_m = 1'b0;
      ptr_m    = (g + 1) % N;
    end else if (exp_pvo) begin
      locked_m = 1'b1;
      lockg_m  = g;
    end
    s_issue = issue_m;
  endtask

  task automatic tick();
    drive();
    #4;
    sample();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int unsigned maxc, input string tag);
    int unsigned n;
    n = 0;
    while (busy() && (n < maxc)) begin
      tick();
      n++;
    end
    check(tag, busy(), 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned   n;
    int            cnt[N];
    logic [DW-1:0] d2;

    areset        = 1'b1;
    req_tvalid    = '0;
    req_tdata     = '0;
    rsp_tready    = '0;
    pipe_tready_i = 1'b0;
    pipe_tvalid_i = 1'b0;
    pipe_tdata_i  = '0;
    rsp_en        = '1;
    pipe_rdy      = 1'b1;
    inj           = 1'b0;
    peak          = 0;
    @(posedge aclk);
    #1;
    do_reset();
    tick();
    check("reset_inflight", s_inflight, 0);
    check("reset_err", s_err, 0);

    // 1: single requester, three beats back to back
    ilog.delete(); rlog.delete(); icyc.delete(); peak = 0;
    for (int i = 0; i < 3; i++) src_q[0].push_back($urandom);
    drain(100, "t1_drain");
    tick();
    check("t1_issues", ilog.size(), 3);
    if (icyc.size() == 3) check("t1_consecutive", icyc[2] - icyc[0], 2);
    check("t1_returns", rlog.size(), 3);
    check("t1_peak", peak, 3);
    check("t1_end_inflight", s_inflight, 0);

    // 2: all requesters saturated, fairness from ptr=0
    do_reset();
    ilog.delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < 10; j++) src_q[i].push_back($urandom);
    drain(400, "t2_drain");
    check("t2_issues", ilog.size(), 40);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < ilog.size(); k++) begin
      check("t2_order", ilog[k], k % N);
      cnt[ilog[k]]++;
    end
    for (int i = 0; i < N; i++) check("t2_per_req", cnt[i], 10);

    // 3: stalled offer keeps its grant against a later requester
    ilog.delete();
    pipe_rdy = 1'b0;
    d2 = $urandom;
    src_q[2].push_back(d2);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) src_q[1].push_back($urandom);
      tick();
      check("t3_hold_data", s_pdo, d2);
      check("t3_no_issue", s_issue, 0);
    end
    pipe_rdy = 1'b1;
    drain(100, "t3_drain");
    check("t3_issues", ilog.size(), 2);
    if (ilog.size() == 2) begin
      check("t3_first", ilog[0], 2);
      check("t3_second", ilog[1], 1);
    end

    // 4: stalled head lane blocks the return path
    rlog.delete();
    rsp_en = 4'b1101;
    src_q[1].push_back($urandom);
    tick();
    src_q[2].push_back($urandom);
    n = 0;
    while (!((pq.size() > 0) && (pq[0].due <= cyc)) && (n < 20)) begin
      tick();
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_pipe_tready_o", s_ptro, 0);
      check("t4_rsp_tvalid", s_rspv, 4'b0010);
    end
    rsp_en = '1;
    drain(100, "t4_drain");
    check("t4_returns", rlog.size(), 2);
    if (rlog.size() == 2) begin
      check("t4_ret_first", rlog[0], 1);
      check("t4_ret_second", rlog[1], 2);
    end

    // 5: FIFO full, pop does not bypass, issue resumes next cycle
    ilog.delete(); rlog.delete();
    rsp_en = '0;
    for (int i = 0; i < 9; i++) src_q[0].push_back($urandom);
    n = 0;
    while ((ilog.size() < 8) && (n < 40)) begin
      tick();
      n++;
    end
    for (int c = 0; c < 3; c++) tick();
    check("t5_inflight_full", s_inflight, 8);
    check("t5_no_offer", s_pvo, 0);
    check("t5_issued", ilog.size(), 8);
    rsp_en = 4'b0001;
    tick();
    check("t5_pop_no_bypass", s_pvo, 0);
    check("t5_one_pop", rlog.size(), 1);
    rsp_en = '0;
    tick();
    check("t5_resume_offer", s_pvo, 1);
    check("t5_resume_issue", s_issue, 1);
    tick();
    check("t5_inflight_again", s_inflight, 8);
    rsp_en = '1;
    drain(100, "t5_drain");

    // 6: untagged return beat, then reset in the middle of traffic
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("t6_drop_ready", s_ptro, 1);
    check("t6_drop_no_rsp", s_rspv, '0);
    tick();
    check("t6_err_set", s_err, 1);
    for (int c = 0; c < 3; c++) tick();
    check("t6_err_sticky", s_err, 1);
    for (int i = 0; i < N; i++) for (int j = 0; j < 5; j++) src_q[i].push_back($urandom);
    for (int c = 0; c < 10; c++) tick();
    do_reset();
    ilog.delete();
    tick();
    check("t6_rst_inflight", s_inflight, 0);
    check("t6_rst_err", s_err, 0);
    check("t6_rst_issue", ilog.size(), 1);
    if (ilog.size() == 1) check("t6_rst_ptr", ilog[0], 0);
    drain(200, "t6_drain");

    // randomized traffic with random backpressure on both sides
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3, 0) == 0) src_q[$urandom_range(N - 1, 0)].push_back($urandom);
      rsp_en   = N'($urandom) | N'($urandom);
      pipe_rdy = ($urandom_range(3, 0) != 0);
      tick();
    end
    rsp_en   = '1;
    pipe_rdy = 1'b1;
    drain(400, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
